// File: rtl/qenc_pkg.sv
// Shared types and helpers for the quadrature encoder front end.
// Gray phase is {A,B}; idle (detent rest) position is 11.
package qenc_pkg;

    typedef logic [1:0] qenc_phase_t;

    typedef enum logic {
        CCW = 1'b0,
        CW  = 1'b1
    } qenc_dir_e;

    typedef enum logic [1:0] {
        DEC_NONE    = 2'd0,
        DEC_UP      = 2'd1,
        DEC_DOWN    = 2'd2,
        DEC_ILLEGAL = 2'd3
    } qenc_dec_e;

    localparam qenc_phase_t QENC_IDLE  = 2'b11;
    localparam int          QENC_ACC_W = 4;

    // Counter width able to hold the value max_val.
    function automatic int qenc_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // CW order is 11 -> 10 -> 00 -> 01 -> 11.
    function automatic qenc_dec_e qenc_decode(input qenc_phase_t prev, input qenc_phase_t cur);
        qenc_dec_e d;
        d = DEC_NONE;
        if ((prev ^ cur) == 2'b11) begin
            d = DEC_ILLEGAL;
        end else begin
            case ({prev, cur})
                4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: d = DEC_UP;
                4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: d = DEC_DOWN;
                default:                                d = DEC_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/qenc_debounce.sv
// Two-flop synchroniser followed by a stability-count filter.
// A new level is accepted after DEB_CYC consecutive differing cycles.
module qenc_debounce
    import qenc_pkg::*;
#(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw_i,
    output logic filt_o
);

    localparam int DC_W = qenc_cnt_w(DEB_CYC);

    logic [1:0]      sync_q;
    logic [DC_W-1:0] cnt_q;
    logic            filt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DC_W'(DEB_CYC - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + DC_W'(1);
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/quad_encoder_if.sv
// Rotary encoder front end: debounced A/B/PB, detent-scaled counter, press classifier.
// Define QENC_LONGPRESS_EN to build the long-press timer; otherwise every release is short.
module quad_encoder_if
    import qenc_pkg::*;
#(
    parameter int CNT_W            = 8,
    parameter int CNT_RST          = 128,
    parameter int DEB_CYC          = 16,
    parameter int STEPS_PER_DETENT = 4,
    parameter int SATURATE         = 0,
    parameter int LONG_CYC         = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             pb_n_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             step_o,
    output logic             dir_o,
    output logic             err_o,
    output logic             pb_level_o,
    output logic             pb_short_o,
    output logic             pb_long_o
);

    if (!(STEPS_PER_DETENT inside {1, 2, 4}) || DEB_CYC < 1 || DEB_CYC > 65535 ||
        LONG_CYC < 1 || CNT_RST < 0) begin : g_bad_param
        $error("quad_encoder_if: illegal parameter set");
    end

    localparam logic [CNT_W-1:0]             CNT_RST_V = CNT_W'(CNT_RST);
    localparam logic [CNT_W-1:0]             CNT_MAX   = {CNT_W{1'b1}};
    localparam logic signed [QENC_ACC_W-1:0] ACC_MAX   = QENC_ACC_W'(STEPS_PER_DETENT);
    localparam logic signed [QENC_ACC_W-1:0] ACC_MIN   = -ACC_MAX;
    localparam logic signed [QENC_ACC_W-1:0] ACC_ONE   = QENC_ACC_W'(1);

    logic a_f, b_f, pb_f;

    qenc_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a  (.clk(clk), .rstn(rstn), .raw_i(a_i),    .filt_o(a_f));
    qenc_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b  (.clk(clk), .rstn(rstn), .raw_i(b_i),    .filt_o(b_f));
    qenc_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pb (.clk(clk), .rstn(rstn), .raw_i(pb_n_i), .filt_o(pb_f));

    qenc_phase_t                    ab_cur, ab_prev_q;
    qenc_dec_e                      dec;
    logic signed [QENC_ACC_W-1:0]   acc_q, acc_sum, acc_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           step_q, step_d, err_q, err_d;
    qenc_dir_e                      dir_q, dir_d;

    assign ab_cur = {a_f, b_f};
    assign dec    = qenc_decode(ab_prev_q, ab_cur);

    always_comb begin
        acc_sum = acc_q;
        case (dec)
            DEC_UP:   acc_sum = acc_q + ACC_ONE;
            DEC_DOWN: acc_sum = acc_q - ACC_ONE;
            default:  acc_sum = acc_q;
        endcase
        acc_d  = acc_sum;
        cnt_d  = cnt_q;
        step_d = 1'b0;
        dir_d  = dir_q;
        err_d  = (dec == DEC_ILLEGAL);

        if (acc_sum == ACC_MAX) begin
            acc_d = '0;
            dir_d = CW;
            if (SATURATE == 0 || cnt_q != CNT_MAX) begin
                cnt_d  = cnt_q + CNT_W'(1);
                step_d = 1'b1;
            end
        end else if (acc_sum == ACC_MIN) begin
            acc_d = '0;
            dir_d = CCW;
            if (SATURATE == 0 || cnt_q != '0) begin
                cnt_d  = cnt_q - CNT_W'(1);
                step_d = 1'b1;
            end
        end

        // A clear wins over a coincident step, which is dropped entirely.
        if (clear_i) begin
            cnt_d  = CNT_RST_V;
            acc_d  = '0;
            step_d = 1'b0;
            dir_d  = dir_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ab_prev_q <= QENC_IDLE;
            acc_q     <= '0;
            cnt_q     <= CNT_RST_V;
            step_q    <= 1'b0;
            dir_q     <= CCW;
            err_q     <= 1'b0;
        end else begin
            ab_prev_q <= ab_cur;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign step_o     = step_q;
    assign dir_o      = (dir_q == CW);
    assign err_o      = err_q;
    assign pb_level_o = ~pb_f;

    logic pb_prev_q, pb_short_q;

`ifdef QENC_LONGPRESS_EN
    localparam int             LP_W   = qenc_cnt_w(LONG_CYC);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYC);

    logic [LP_W-1:0] press_q;
    logic            pb_long_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            press_q    <= '0;
            pb_prev_q  <= 1'b0;
            pb_short_q <= 1'b0;
            pb_long_q  <= 1'b0;
        end else begin
            pb_prev_q  <= pb_level_o;
            pb_short_q <= 1'b0;
            pb_long_q  <= 1'b0;
            if (pb_level_o) begin
                if (press_q != LP_MAX) begin
                    press_q   <= press_q + LP_W'(1);
                    pb_long_q <= ((press_q + LP_W'(1)) == LP_MAX);
                end
            end else begin
                press_q    <= '0;
                pb_short_q <= pb_prev_q && (press_q != LP_MAX);
            end
        end
    end

    assign pb_long_o = pb_long_q;
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pb_prev_q  <= 1'b0;
            pb_short_q <= 1'b0;
        end else begin
            pb_prev_q  <= pb_level_o;
            pb_short_q <= pb_prev_q && !pb_level_o;
        end
    end

    assign pb_long_o = 1'b0;
`endif

    assign pb_short_o = pb_short_q;

endmodule

// File: tb/tb_quad_encoder_if.sv
// Bench for quad_encoder_if: main instance plus 4-bit wrap and saturate instances on shared pins.
// Expected step results are queued as each detent is driven and popped when step_o fires.
`timescale 1ns/1ps
module tb_quad_encoder_if;

    localparam int HOLD = 10;

    logic clk = 1'b0;
    logic rstn, a_i, b_i, pb_n_i, clear_i;

    logic [7:0] cnt_o;
    logic       step_o, dir_o, err_o, pb_level_o, pb_short_o, pb_long_o;
    logic [3:0] w_cnt_o, s_cnt_o;
    logic       w_step, w_dir, w_err, w_lvl, w_short, w_long;
    logic       s_step, s_dir, s_err, s_lvl, s_short, s_long;

    quad_encoder_if #(.CNT_W(8), .CNT_RST(128), .DEB_CYC(4), .STEPS_PER_DETENT(4),
                      .SATURATE(0), .LONG_CYC(100)) u_dut (
        .clk(clk), .rstn(rstn), .a_i(a_i), .b_i(b_i), .pb_n_i(pb_n_i), .clear_i(clear_i),
        .cnt_o(cnt_o), .step_o(step_o), .dir_o(dir_o), .err_o(err_o),
        .pb_level_o(pb_level_o), .pb_short_o(pb_short_o), .pb_long_o(pb_long_o));

    quad_encoder_if #(.CNT_W(4), .CNT_RST(15), .DEB_CYC(4), .STEPS_PER_DETENT(4),
                      .SATURATE(0), .LONG_CYC(100)) u_wrap (
        .clk(clk), .rstn(rstn), .a_i(a_i), .b_i(b_i), .pb_n_i(pb_n_i), .clear_i(clear_i),
        .cnt_o(w_cnt_o), .step_o(w_step), .dir_o(w_dir), .err_o(w_err),
        .pb_level_o(w_lvl), .pb_short_o(w_short), .pb_long_o(w_long));

    quad_encoder_if #(.CNT_W(4), .CNT_RST(15), .DEB_CYC(4), .STEPS_PER_DETENT(4),
                      .SATURATE(1), .LONG_CYC(100)) u_sat (
        .clk(clk), .rstn(rstn), .a_i(a_i), .b_i(b_i), .pb_n_i(pb_n_i), .clear_i(clear_i),
        .cnt_o(s_cnt_o), .step_o(s_step), .dir_o(s_dir), .err_o(s_err),
        .pb_level_o(s_lvl), .pb_short_o(s_short), .pb_long_o(s_long));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];           // {dir, cnt} expected at each main step
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] m_cnt;
    logic [3:0] w_cnt, s_cnt;
    int m_steps = 0, w_steps = 0, s_steps = 0, m_errs = 0;
    int seen_m_steps = 0, seen_w_steps = 0, seen_s_steps = 0;
    int seen_errs = 0, seen_short = 0, seen_long = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    always begin
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (rstn) begin
            if (step_o) begin
                seen_m_steps++;
                chk("step_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("step_dir_cnt", 32'({dir_o, cnt_o}), 32'(e));
                end
            end
            if (w_step)     seen_w_steps++;
            if (s_step)     seen_s_steps++;
            if (err_o)      seen_errs++;
            if (pb_short_o) seen_short++;
            if (pb_long_o)  seen_long++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_ab(input logic [1:0] ph);
        @(negedge clk);
        a_i = ph[1];
        b_i = ph[0];
        repeat (HOLD - 1) @(negedge clk);
    endtask

    task automatic model_detent(input logic up);
        if (up) begin
            m_cnt = m_cnt + 8'd1;
            w_cnt = w_cnt + 4'd1;
            if (s_cnt != 4'd15) begin s_cnt = s_cnt + 4'd1; s_steps++; end
        end else begin
            m_cnt = m_cnt - 8'd1;
            w_cnt = w_cnt - 4'd1;
            if (s_cnt != 4'd0) begin s_cnt = s_cnt - 4'd1; s_steps++; end
        end
        m_steps++;
        w_steps++;
        exp_q.push_back({up, m_cnt});
    endtask

    task automatic cw_detent();
        drive_ab(2'b10); drive_ab(2'b00); drive_ab(2'b01);
        model_detent(1'b1);
        drive_ab(2'b11);
    endtask

    task automatic ccw_detent();
        drive_ab(2'b01); drive_ab(2'b00); drive_ab(2'b10);
        model_detent(1'b0);
        drive_ab(2'b11);
    endtask

    task automatic chk_models(input string tag);
        chk({tag, "_cnt"},     cnt_o,        m_cnt);
        chk({tag, "_steps"},   seen_m_steps, m_steps);
        chk({tag, "_wcnt"},    w_cnt_o,      w_cnt);
        chk({tag, "_wsteps"},  seen_w_steps, w_steps);
        chk({tag, "_scnt"},    s_cnt_o,      s_cnt);
        chk({tag, "_ssteps"},  seen_s_steps, s_steps);
        chk({tag, "_errs"},    seen_errs,    m_errs);
    endtask

    task automatic reset_models();
        m_cnt = 8'd128;
        w_cnt = 4'd15;
        s_cnt = 4'd15;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        a_i = 1'b1; b_i = 1'b1; pb_n_i = 1'b1; clear_i = 1'b0; rstn = 1'b0;
        reset_models();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cnt", cnt_o, 128);
        chk("rst_step", step_o, 0);
        chk("rst_dir", dir_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_pb_level", pb_level_o, 0);
        chk("rst_pb_short", pb_short_o, 0);
        chk("rst_pb_long", pb_long_o, 0);
        chk("rst_wcnt", w_cnt_o, 15);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // CW detent with raw-to-step latency measurement
        drive_ab(2'b10); drive_ab(2'b00); drive_ab(2'b01);
        model_detent(1'b1);
        @(negedge clk);
        a_i = 1'b1; b_i = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (step_o) begin lat = k; break; end
        end
        chk("step_latency", lat, 7);
        repeat (5) @(negedge clk);
        chk_models("cw");
        chk("cw_dir", dir_o, 1);
        chk("cw_wrap_to_zero", w_cnt_o, 0);
        chk("sat_dir_at_limit", s_dir, 1);

        // Half detent then reversal: accumulator walks back, no step
        drive_ab(2'b10); drive_ab(2'b00); drive_ab(2'b10); drive_ab(2'b11);
        chk_models("reversal");

        // CCW detent: wrap 0 -> 15, saturate 15 -> 14
        ccw_detent();
        chk_models("ccw");
        chk("ccw_dir", dir_o, 0);

        // Short glitches on A are rejected
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            a_i = 1'b0;
            repeat (3) @(negedge clk);
            a_i = 1'b1;
            repeat (HOLD) @(negedge clk);
        end
        chk_models("bounce");

        // Illegal jump must not disturb the accumulator (+2 then +2 more completes a detent)
        drive_ab(2'b10); drive_ab(2'b00);
        drive_ab(2'b11);
        m_errs++;
        chk("illegal_err_count", seen_errs, m_errs);
        chk("illegal_cnt_hold", cnt_o, m_cnt);
        drive_ab(2'b10);
        model_detent(1'b1);
        drive_ab(2'b00);
        drive_ab(2'b11);
        m_errs++;
        chk_models("illegal");

        // clear_i in the same cycle as a step
        drive_ab(2'b10); drive_ab(2'b00); drive_ab(2'b01);
        @(negedge clk);
        a_i = 1'b1; b_i = 1'b1;
        repeat (6) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        reset_models();
        chk("clear_cnt", cnt_o, 128);
        chk("clear_step", step_o, 0);
        repeat (HOLD) @(negedge clk);
        chk_models("clear");

        // Short press (50 cycles)
        @(negedge clk);
        pb_n_i = 1'b0;
        repeat (50) @(negedge clk);
        chk("pb_level_pressed", pb_level_o, 1);
        pb_n_i = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!pb_level_o) begin lat = k; break; end
        end
        chk("pb_release_latency", lat, 6);
        chk("pb_short_not_early", pb_short_o, 0);
        @(negedge clk);
        chk("pb_short_pulse", pb_short_o, 1);
        repeat (5) @(negedge clk);
        chk("short_press_short_count", seen_short, 1);

        // Long press (about 150 cycles)
        @(negedge clk);
        pb_n_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pb_level_o) begin lat = k; break; end
        end
        chk("pb_press_latency", lat, 6);
        lat = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (pb_long_o) begin lat = k; break; end
        end
`ifdef QENC_LONGPRESS_EN
        chk("pb_long_latency", lat, 100);
`else
        chk("pb_long_latency", lat, 0);
`endif
        repeat (40) @(negedge clk);
        pb_n_i = 1'b1;
        repeat (15) @(negedge clk);
`ifdef QENC_LONGPRESS_EN
        chk("long_press_short_count", seen_short, 1);
        chk("long_press_long_count", seen_long, 1);
`else
        chk("long_press_short_count", seen_short, 2);
        chk("long_press_long_count", seen_long, 0);
`endif

        // Reset with a press and half a detent in flight
        @(negedge clk);
        pb_n_i = 1'b0;
        drive_ab(2'b10); drive_ab(2'b00);
        @(negedge clk);
        rstn = 1'b0;
        a_i = 1'b1; b_i = 1'b1; pb_n_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_cnt", cnt_o, 128);
        chk("midrst_pb_level", pb_level_o, 0);
        rstn = 1'b1;
        reset_models();
        repeat (20) @(negedge clk);
        chk_models("midrst");
        chk("midrst_short_count", seen_short, seen_long == 1 ? 1 : 2);
        cw_detent();
        chk_models("post_rst");

        chk("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/quad_encoder_if.md
# quad_encoder_if

Parametrised front end for a mechanical quadrature rotary encoder with an integrated pushbutton. It synchronises and debounces the raw A/B/PB pins and decodes full-quadrature Gray transitions into a detent-scaled up/down count with wrap or saturate behaviour. It also classifies button presses as short or long. It sits between the board pins and the UI/menu logic, which consumes `cnt_o` and the single-cycle event pulses.

## Interface
- `CNT_W`, 8: width of the position counter.
- `CNT_RST`, 128: reset and clear value of `cnt_o`; must be less than 2^CNT_W.
- `DEB_CYC`, 16: consecutive stable cycles required to accept a new level on each input; range 1..65535.
- `STEPS_PER_DETENT`, 4: valid quadrature transitions per count; must be 1, 2 or 4.
- `SATURATE`, 0: 0 wraps `cnt_o` modulo 2^CNT_W; 1 clamps it at 0 and 2^CNT_W-1.
- `LONG_CYC`, 4096: filtered-held cycles that constitute a long press.
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset, synchronous, active-low.
- `a_i`, input, 1: raw encoder A, asynchronous, idle high.
- `b_i`, input, 1: raw encoder B, asynchronous, idle high.
- `pb_n_i`, input, 1: raw pushbutton, asynchronous, active-low.
- `clear_i`, input, 1: synchronous load of `CNT_RST` into `cnt_o`.
- `cnt_o`, output, CNT_W: position count.
- `step_o`, output, 1: one-cycle pulse whenever `cnt_o` changes due to rotation.
- `dir_o`, output, 1: direction of the last step; 1 = CW (up), 0 = CCW.
- `err_o`, output, 1: one-cycle pulse on an illegal transition (both filtered phases change in the same cycle).
- `pb_level_o`, output, 1: debounced button state; 1 = pressed.
- `pb_short_o`, output, 1: one-cycle pulse on release of a short press.
- `pb_long_o`, output, 1: one-cycle pulse when a press reaches `LONG_CYC`.

## Operation
- **Synchronisers:** each raw input passes through a 2-flop synchroniser. Reset value is 1 (idle/released).
- **Debounce (per input):**
  - A stability counter counts cycles in which the synchronised value differs from the filtered value. Any equal cycle zeroes the counter.
  - On the DEB_CYC-th consecutive differing cycle, the filtered value takes the new level and the counter zeroes.
  - Filtered A, B and PB reset to 1.
- **Quadrature decode on filtered {A,B}, Gray sequence 11→10→00→01→11:**
  - Following this sequence is CW (+1); the reverse is CCW (-1). No change is 0.
  - Both bits changing at once is illegal: `err_o` pulses and the sub-step accumulator is untouched.
  - The signed sub-step accumulator range is ±STEPS_PER_DETENT.
  - When it reaches +STEPS_PER_DETENT, it zeroes, `cnt_o` increments, and `dir_o` goes to 1.
  - When it reaches -STEPS_PER_DETENT, it zeroes, `cnt_o` decrements, and `dir_o` goes to 0.
  - A direction reversal mid-detent simply walks the accumulator back; no step is issued.
- **Arithmetic:**
  - With SATURATE=0: 2^CNT_W-1 + 1 → 0, and 0 - 1 → 2^CNT_W-1. `step_o` pulses in both cases.
  - With SATURATE=1: a step at a limit leaves `cnt_o` unchanged, `step_o` does not pulse, and `dir_o` still updates.
- **clear_i:** loads `CNT_RST` and zeroes the accumulator. It has priority over a step in the same cycle; that step is discarded and `step_o` stays 0.
- **Pushbutton:**
  - A press-duration counter runs while the filtered PB is pressed and saturates at LONG_CYC.
  - `pb_long_o` pulses once, in the cycle the counter reaches LONG_CYC.
  - `pb_short_o` pulses on release only if LONG_CYC was not reached.
  - The counter zeroes on release.
- **Reset mid-operation:** all state returns to reset values. Any press or detent in progress is abandoned, and no event pulses are issued for it.

## Timing
- Reset values:
  - `cnt_o` = CNT_RST.
  - `step_o`, `err_o`, `pb_short_o`, `pb_long_o`, `pb_level_o` = 0.
  - `dir_o` = 0.
  - Accumulator = 0.
- Latency from a raw pin change (held stable) to the filtered-level change is 2 + DEB_CYC cycles.
- `cnt_o`, `step_o` and `dir_o` update 1 cycle after the filtered change. Total raw-to-count latency is 3 + DEB_CYC cycles.
- `pb_level_o` equals the inverted filtered PB with no extra delay.
- `pb_short_o` is asserted 1 cycle after the filtered release.
- All outputs are registered, and each event pulse is exactly 1 cycle wide.

## Configuration
- **QENC_LONGPRESS_EN defined:** long-press detection is present as described above.
- **QENC_LONGPRESS_EN undefined:**
  - The press-duration counter is removed and `pb_long_o` is tied to 0.
  - Every filtered release produces `pb_short_o`.
  - `LONG_CYC` is ignored.

## Structure
- Package `qenc_pkg` contains:
  - a typedef for the 2-bit Gray phase;
  - the enum `qenc_dir_e` {CCW, CW};
  - the function `qenc_decode(prev, cur)`, returning +1, 0, -1 or illegal;
  - localparam width helpers, e.g. `$clog2(DEB_CYC+1)`.
- Sub-module `qenc_debounce` contains the synchroniser plus stability counter (parameter DEB_CYC) and is instantiated 3 times.

## Test plan
- **Reset:** assert rstn=0 for 2 cycles → `cnt_o`=128, all pulses 0, `pb_level_o`=0.
- **CW detent:** DEB_CYC=4, STEPS=4, drive 11→10→00→01→11, each phase held 10 cycles → `cnt_o`=129, a single `step_o` exactly 7 cycles after the final edge, `dir_o`=1. Half a detent followed by a reversal → no step.
- **Wrap vs saturate:** CNT_W=4, CNT_RST=15, one CW detent → `cnt_o`=0 with SATURATE=0; `cnt_o`=15 with no `step_o` when SATURATE=1.
- **Bounce and illegal transition:** 3-cycle glitches on A with DEB_CYC=4 → no change. Forcing filtered 11→00 → one `err_o`, `cnt_o` unchanged.
- **Pushbutton:** LONG_CYC=100, press for 50 cycles → one `pb_short_o`. Press for 150 cycles → `pb_long_o` at cycle 100 and no `pb_short_o` on release. With the macro undefined → `pb_short_o` on both releases.
- **clear_i:** assert `clear_i` in the same cycle as a step → `cnt_o`=CNT_RST, `step_o`=0.
